// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared NPC core constants, instruction field positions and IFU state encoding.
package npc_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [2:0] {
    IFU_RESET_WAIT,
    IFU_REQ,
    IFU_WAIT,
    IFU_HOLD,
    IFU_HALTED
  } ifu_state_e;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction memory port and decode-side port bundles for ifu_fetch.
interface ifu_imem_if #(parameter int XLEN = 64);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
endinterface

interface ifu_dec_if #(parameter int XLEN = 64);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_fault;

  modport master (
    output out_valid, out_pc, out_inst, out_opcode, out_funct3, out_funct7, out_fault,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_pc, out_inst, out_opcode, out_funct3, out_funct7, out_fault,
    output out_ready
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - fetch PC register with +4 advance, redirect override and alignment flags.
module ifu_pc_gen
  import npc_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_aligned,
  output logic            pc_next_aligned
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect has priority over sequential advance; +4 wraps modulo 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc              = pc_q;
  assign pc_next         = pc_d;
  assign pc_aligned      = word_aligned(pc_q[1:0]);
  assign pc_next_aligned = word_aligned(pc_d[1:0]);

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch FSM with redirect, halt and fault handling.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  ifu_imem_if.master      imem,
  ifu_dec_if.master       dec,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);

  ifu_state_e      state_q, state_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;

  logic            pc_redirect;
  logic            pc_advance;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            pc_aligned;
  logic            pc_next_aligned;
  logic            req_fire;

  ifu_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect        (pc_redirect),
    .redirect_pc     (redirect_pc),
    .advance         (pc_advance),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_aligned      (pc_aligned),
    .pc_next_aligned (pc_next_aligned)
  );

  assign req_fire = req_valid_q && imem.imem_req_ready;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    out_pc_d    = out_pc_q;
    inst_d      = inst_q;
    fault_d     = fault_q;
    pc_redirect = 1'b0;
    pc_advance  = 1'b0;

    case (state_q)
      IFU_RESET_WAIT: begin
        pc_redirect = redirect_valid;
        state_d     = IFU_REQ;
      end
      IFU_REQ: begin
        if (redirect_valid) begin
          pc_redirect = 1'b1;
          // A request accepted in the redirect cycle is already in flight; discard its reply.
          if (req_fire) begin
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end
        end else if (!pc_aligned) begin
          out_pc_d = pc;
          inst_d   = NOP_INST;
          fault_d  = 1'b1;
          state_d  = IFU_HOLD;
        end else if (req_fire) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_redirect = 1'b1;
          if (imem.imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem.imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            out_pc_d = pc;
            inst_d   = imem.imem_rsp_err ? NOP_INST : imem.imem_rsp_data;
            fault_d  = imem.imem_rsp_err;
            state_d  = IFU_HOLD;
          end
        end
      end
      IFU_HOLD: begin
        // Halt outranks both redirect and consumption of the held word.
        if (halt) begin
          state_d = IFU_HALTED;
        end else if (redirect_valid) begin
          pc_redirect = 1'b1;
          state_d     = IFU_REQ;
        end else if (dec.out_ready) begin
          pc_advance = 1'b1;
          state_d    = IFU_REQ;
        end
      end
      IFU_HALTED: begin
        state_d = IFU_HALTED;
      end
      default: begin
        state_d = IFU_RESET_WAIT;
      end
    endcase

    req_valid_d = (state_d == IFU_REQ) && pc_next_aligned;
    out_valid_d = (state_d == IFU_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IFU_RESET_WAIT;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      inst_q      <= NOP_INST;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      inst_q      <= inst_d;
      fault_q     <= fault_d;
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = pc;

  assign dec.out_valid  = out_valid_q;
  assign dec.out_pc     = out_pc_q;
  assign dec.out_inst   = inst_q;
  assign dec.out_fault  = fault_q;
  assign dec.out_opcode = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign dec.out_funct3 = inst_q[FUNCT3_MSB:FUNCT3_LSB];
  assign dec.out_funct7 = inst_q[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch with a small latency-configurable memory model.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;

  int n_cmp;
  int n_bad;
  int lat;
  logic err_mode;

  ifu_imem_if #(.XLEN(64)) imem();
  ifu_dec_if  #(.XLEN(64)) dec();

  ifu_fetch #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .dec            (dec),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0000_0413;
      64'h8000_0004: return 32'h0020_C1B3;
      64'h8000_0100: return 32'h4020_8033;
      default:       return 32'h0000_0093;
    endcase
  endfunction

  // Memory: accepts at a rising edge, answers lat edges later with a one-cycle pulse.
  initial begin
    logic        acc;
    logic [63:0] a;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    imem.imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      acc = rst_n && imem.imem_req_valid && imem.imem_req_ready;
      a   = imem.imem_addr;
      if (acc) begin
        repeat (lat) @(posedge clk);
        #1;
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = err_mode ? 32'hFFFF_FFFF : mem_word(a);
        imem.imem_rsp_err   = err_mode;
        @(posedge clk);
        #1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_err   = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!dec.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dec.out_valid) chk({tag, "_timeout"}, 64'(dec.out_valid), 64'd1);
  endtask

  task automatic redirect_pulse(input logic [63:0] pc, input logic with_fire);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    dec.out_ready  = with_fire;
    @(negedge clk);
    redirect_valid = 1'b0;
    dec.out_ready  = 1'b0;
  endtask

  task automatic fire();
    dec.out_ready = 1'b1;
    @(negedge clk);
    dec.out_ready = 1'b0;
  endtask

  initial begin
    int saw;
    int n;
    logic [31:0] held;
    n_cmp = 0;
    n_bad = 0;
    lat = 1;
    err_mode = 1'b0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    halt = 1'b0;
    dec.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
    chk("rst_addr",      imem.imem_addr, RST_PC);
    chk("rst_out_valid", 64'(dec.out_valid), 64'd0);
    chk("rst_out_pc",    dec.out_pc, RST_PC);
    chk("rst_out_inst",  64'(dec.out_inst), 64'(NOP));
    chk("rst_out_fault", 64'(dec.out_fault), 64'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("first_req_addr",  imem.imem_addr, RST_PC);
    @(negedge clk);
    chk("wait_no_req", 64'(imem.imem_req_valid), 64'd0);
    @(negedge clk);
    chk("i0_valid",  64'(dec.out_valid), 64'd1);
    chk("i0_pc",     dec.out_pc, RST_PC);
    chk("i0_inst",   64'(dec.out_inst), 64'h0000_0413);
    chk("i0_opcode", 64'(dec.out_opcode), 64'h13);
    chk("i0_funct3", 64'(dec.out_funct3), 64'h0);
    chk("i0_fault",  64'(dec.out_fault), 64'd0);

    held = dec.out_inst;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_inst",  64'(dec.out_inst), 64'h0000_0413);
      chk("stall_valid", 64'(dec.out_valid), 64'd1);
      chk("stall_req",   64'(imem.imem_req_valid), 64'd0);
    end

    fire();
    chk("i1_req_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("i1_req_addr",  imem.imem_addr, 64'h8000_0004);
    chk("i1_gap_valid", 64'(dec.out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("i1_valid",  64'(dec.out_valid), 64'd1);
    chk("i1_pc",     dec.out_pc, 64'h8000_0004);
    chk("i1_opcode", 64'(dec.out_opcode), 64'h33);
    chk("i1_funct3", 64'(dec.out_funct3), 64'h4);
    chk("i1_funct7", 64'(dec.out_funct7), 64'h0);

    lat = 3;
    fire();
    chk("i2_req_addr", imem.imem_addr, 64'h8000_0008);
    @(negedge clk);
    redirect_pulse(64'h8000_0100, 1'b0);
    lat = 1;
    saw = 0;
    n = 0;
    while (!imem.imem_req_valid && n < 20) begin
      if (dec.out_valid) saw = 1;
      @(negedge clk);
      n++;
    end
    chk("drop_no_out_valid", 64'(saw), 64'd0);
    chk("redir_req_valid",   64'(imem.imem_req_valid), 64'd1);
    chk("redir_req_addr",    imem.imem_addr, 64'h8000_0100);
    wait_out("redir_out");
    chk("redir_pc",     dec.out_pc, 64'h8000_0100);
    chk("redir_inst",   64'(dec.out_inst), 64'h4020_8033);
    chk("redir_funct7", 64'(dec.out_funct7), 64'h20);

    redirect_pulse(64'h8000_0102, 1'b1);
    chk("mis_valid_drop", 64'(dec.out_valid), 64'd0);
    saw = 0;
    n = 0;
    while (!dec.out_valid && n < 20) begin
      if (imem.imem_req_valid) saw = 1;
      @(negedge clk);
      n++;
    end
    chk("mis_no_req", 64'(saw), 64'd0);
    chk("mis_valid",  64'(dec.out_valid), 64'd1);
    chk("mis_fault",  64'(dec.out_fault), 64'd1);
    chk("mis_inst",   64'(dec.out_inst), 64'(NOP));
    chk("mis_pc",     dec.out_pc, 64'h8000_0102);

    redirect_pulse(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    wait_out("wrap_out");
    chk("wrap_pc",    dec.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_fault", 64'(dec.out_fault), 64'd0);
    fire();
    chk("wrap_req_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("wrap_req_addr",  imem.imem_addr, 64'h0);
    @(negedge clk);
    wait_out("wrap0_out");
    chk("wrap0_pc", dec.out_pc, 64'h0);

    err_mode = 1'b1;
    redirect_pulse(64'h8000_0200, 1'b0);
    wait_out("err_out");
    chk("err_fault", 64'(dec.out_fault), 64'd1);
    chk("err_inst",  64'(dec.out_inst), 64'(NOP));
    chk("err_pc",    dec.out_pc, 64'h8000_0200);
    err_mode = 1'b0;

    halt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h9000_0000;
    @(negedge clk);
    halt = 1'b0;
    redirect_valid = 1'b0;
    saw = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem.imem_req_valid) saw++;
      if (dec.out_valid) n++;
      @(negedge clk);
    end
    chk("halt_no_req",   64'(saw), 64'd0);
    chk("halt_no_valid", 64'(n), 64'd0);
    chk("halt_pc_kept",  imem.imem_addr, 64'h8000_0200);

    rst_n = 1'b0;
    @(negedge clk);
    lat = 2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_req_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("rst2_req_addr",  imem.imem_addr, RST_PC);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_rsp_in_reset", 64'(imem.imem_rsp_valid), 64'd1);
    chk("rst2_no_valid",     64'(dec.out_valid), 64'd0);
    @(negedge clk);
    lat = 1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_restart_req", imem.imem_addr, RST_PC);
    chk("rst2_restart_nov", 64'(dec.out_valid), 64'd0);
    wait_out("rst2_out");
    chk("rst2_pc",    dec.out_pc, RST_PC);
    chk("rst2_inst",  64'(dec.out_inst), 64'h0000_0413);
    chk("rst2_fault", 64'(dec.out_fault), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
